// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for Data_Memory.
// Big-endian byte addressing; all outputs registered.
// Optional feature macro LSU_SUBWORD_EN: when defined, byte/half accesses are
// supported (lane extraction on loads, read-modify-write on stores). When not
// defined, only word accesses are legal and byte/half requests fault.
module load_store_unit #(
    parameter int unsigned MEM_LIMIT = 120
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic [31:0] DAddr,
    output logic [31:0] DataIn,
    input  logic [31:0] Dataout,
    output logic        nRD,
    output logic        nWR
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        nrd_q, nrd_d;
    logic        nwr_q, nwr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] datain_q, datain_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [1:0]  off_q, off_d;
    logic        req_fault;
    logic [32:0] last_byte;

    // Legality of the request currently presented; the 33-bit sum keeps
    // addresses near 2^32 from wrapping back into range.
    always_comb begin
        last_byte = {1'b0, addr[31:2], 2'b00} + 33'd3;
        req_fault = (last_byte > 33'(MEM_LIMIT));
`ifdef LSU_SUBWORD_EN
        case (size)
            2'b00:   req_fault = req_fault;
            2'b01:   req_fault = req_fault | addr[0];
            2'b10:   req_fault = req_fault | (addr[1:0] != 2'b00);
            default: req_fault = 1'b1;
        endcase
`else
        req_fault = req_fault | (size != 2'b10) | (addr[1:0] != 2'b00);
`endif
    end

`ifdef LSU_SUBWORD_EN
    logic [7:0]  lane8;
    logic [15:0] lane16;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Lane extraction for loads and lane merge for read-modify-write stores;
    // the latched store data sits right-aligned in datain_q until the merge.
    always_comb begin
        case (off_q)
            2'd0:    lane8 = Dataout[31:24];
            2'd1:    lane8 = Dataout[23:16];
            2'd2:    lane8 = Dataout[15:8];
            default: lane8 = Dataout[7:0];
        endcase
        lane16 = off_q[1] ? Dataout[15:0] : Dataout[31:16];
        case (size_q)
            2'b00:   load_val = {{24{sext_q & lane8[7]}}, lane8};
            2'b01:   load_val = {{16{sext_q & lane16[15]}}, lane16};
            default: load_val = Dataout;
        endcase
        merged = Dataout;
        if (size_q == 2'b00) begin
            case (off_q)
                2'd0:    merged[31:24] = datain_q[7:0];
                2'd1:    merged[23:16] = datain_q[7:0];
                2'd2:    merged[15:8]  = datain_q[7:0];
                default: merged[7:0]   = datain_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[15:0] = datain_q[15:0];
        end else begin
            merged[31:16] = datain_q[15:0];
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{we_q, size_q, sext_q, off_q};
`endif

    // Next-state and registered-output computation; strobes default inactive
    // so each is low for exactly the one cycle spent in RD or WR.
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        nrd_d    = 1'b1;
        nwr_d    = 1'b1;
        fault_d  = fault_q;
        rdata_d  = rdata_q;
        daddr_d  = daddr_q;
        datain_d = datain_q;
        we_d     = we_q;
        size_d   = size_q;
        sext_d   = sext_q;
        off_d    = off_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    sext_d  = sext;
                    off_d   = addr[1:0];
                    daddr_d = {addr[31:2], 2'b00};
                    rdata_d = '0;
                    fault_d = 1'b0;
                    if (we) begin
                        datain_d = wdata;
                    end
                    if (req_fault) begin
                        fault_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (!we || size != 2'b10) begin
                        nrd_d   = 1'b0;
                        state_d = RD;
                    end else begin
                        nwr_d   = 1'b0;
                        state_d = WR;
                    end
                end
            end
            RD: begin
`ifdef LSU_SUBWORD_EN
                if (we_q) begin
                    datain_d = merged;
                    nwr_d    = 1'b0;
                    state_d  = WR;
                end else begin
                    rdata_d = load_val;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
`else
                rdata_d = Dataout;
                done_d  = 1'b1;
                state_d = DONE;
`endif
            end
            WR: begin
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset forces both strobes high at once.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            nrd_q    <= 1'b1;
            nwr_q    <= 1'b1;
            rdata_q  <= '0;
            daddr_q  <= '0;
            datain_q <= '0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            sext_q   <= 1'b0;
            off_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            nrd_q    <= nrd_d;
            nwr_q    <= nwr_d;
            rdata_q  <= rdata_d;
            daddr_q  <= daddr_d;
            datain_q <= datain_d;
            we_q     <= we_d;
            size_q   <= size_d;
            sext_q   <= sext_d;
            off_q    <= off_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign fault  = fault_q;
    assign rdata  = rdata_q;
    assign DAddr  = daddr_q;
    assign DataIn = datain_q;
    assign nRD    = nrd_q;
    assign nWR    = nwr_q;
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access initiator between the CPU datapath and `Data_Memory`. Accepts one load/store request at a time from the CPU and drives the memory's `DAddr`/`DataIn`/`nRD`/`nWR` port. Performs sub-word stores as read-modify-write and returns sign- or zero-extended load data. Flags misaligned and out-of-range accesses. Memory is byte-addressed big-endian: the byte at word address +0 is `[31:24]`. Reads are combinational; writes commit at negedge `CLK` while `nWR`=0.

## Interface
Parameters:
- `MEM_LIMIT`, default 120: highest valid byte address.

Ports:
- `CLK`, in, 1: clock, rising-edge.
- `Reset`, in, 1: asynchronous, active-high.
- `req`, in, 1: request valid; sampled only while `busy`=0.
- `we`, in, 1: 1 = store, 0 = load.
- `size`, in, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `sext`, in, 1: sign-extend load data.
- `addr`, in, 32: byte address.
- `wdata`, in, 32: store data, right-aligned.
- `busy`, out, 1: operation in flight.
- `done`, out, 1: one-cycle completion pulse.
- `fault`, out, 1: valid with `done`; the request was rejected.
- `rdata`, out, 32: load result; valid with `done`.
- `DAddr`, out, 32: memory word address (`addr & ~3`).
- `DataIn`, out, 32: memory write word.
- `Dataout`, in, 32: memory read word.
- `nRD`, out, 1: active-low read strobe.
- `nWR`, out, 1: active-low write strobe.

## Operation
- FSM states: IDLE, RD, WR, DONE.
- IDLE, `req`=1 at a posedge: latch `we`, `size`, `sext`, `addr`, `wdata`; set `busy`. Then:
  - Fault → DONE.
  - Load → RD.
  - Word store → WR.
  - Sub-word store → RD.
- Fault conditions:
  - `size`=11.
  - Half with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - (`addr & ~3`)+3 > `MEM_LIMIT`.
  - On fault, `nRD` and `nWR` are never asserted and `rdata`=0.
- RD: `nRD`=0 for exactly one cycle; `Dataout` is captured at the closing posedge.
  - Load → DONE with extracted lane. Byte lane = `Dataout[31-8*off -: 8]`, off=`addr[1:0]`. Half at off 0 = `[31:16]`, at off 2 = `[15:0]`.
  - Sub-word store → WR with `wdata[7:0]` or `wdata[15:0]` merged into the captured word at that lane.
- WR: `nWR`=0 for exactly one cycle with `DataIn` stable; the memory commits at the mid-cycle negedge. → DONE.
- DONE: `done`=1 for one cycle; `busy` stays 1; → IDLE. A new request is accepted from the following cycle.
- `req` while `busy`=1: ignored, not queued.
- All outputs are registered.
- Reset values: state IDLE, `busy`=0, `done`=0, `fault`=0, `rdata`=0, `DAddr`=0, `DataIn`=0, `nRD`=1, `nWR`=1.

## Timing
- Latency from the accepting posedge to `done` high:
  - Fault: 1 cycle.
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
- `nRD` and `nWR` are never low in the same cycle. They change only at posedge, so they are stable at the memory's negedge write.
- `DAddr` holds its value from the accepting edge until the next accept.
- Reset mid-operation: strobes go high immediately (asynchronously). If `Reset` rises before the WR-cycle negedge, no write occurs. Any pending `done` is dropped.

## Configuration
- `LSU_SUBWORD_EN` defined: byte and half accesses are supported as described, including read-modify-write stores.
- Not defined: only `size`=10 is legal. Byte and half requests fault. Stores always go IDLE→WR→DONE, and the merge/extract logic is absent.

## Test plan
- Memory bytes 8..11 = 80,12,34,56; word load at `addr`=8 → `done` 2 cycles after accept, `rdata`=0x80123456, `fault`=0, `nRD` low exactly 1 cycle.
- Byte load at `addr`=8: with `sext`=1 → `rdata`=0xFFFFFF80; with `sext`=0 → 0x00000080. Half load at `addr`=10, `sext`=1 → 0x00003456.
- Half store at `addr`=10, `wdata`=0x0000ABCD → `nRD` low 1 cycle, then `nWR` low 1 cycle with `DataIn`=0x8012ABCD. `done` arrives 3 cycles after accept; a subsequent word load at 8 returns 0x8012ABCD.
- Word load at `addr`=6, and separately at `addr`=120 → `done`=`fault`=1 one cycle after accept, `rdata`=0, strobes never low.
- `req` held high throughout a word store → exactly one operation per accept; the second request is accepted only in the cycle after `done`.
- `Reset` raised during the WR cycle before the negedge of a word store to 8 of 0xDEADBEEF → `nWR` goes high immediately, `busy`=0, and the word at 8 is unchanged.
